// File: rtl/nd_pkt_fifo.sv
// nd_pkt_fifo
// Packet-aware FIFO for the USB receiver's non-data path (tokens and
// handshakes). The receive decoder writes bytes on one side and the protocol
// controller reads them on the other. A packet's bytes become readable only
// after its last byte commits it. A packet can be aborted while it is being
// written. A packet that overflows is thrown away whole instead of being
// truncated.
//
// Parameters
//   DATA_WIDTH  bits per entry
//   DEPTH       number of entries (>= 2, need not be a power of two)
//   AF_MARGIN   almost_full asserts when free entries <= AF_MARGIN
//   CW          width of the count outputs, $clog2(DEPTH+1)
//
// Ports
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   w_enable     write w_data at the write pointer
//   w_data       write data
//   w_last       written byte ends the packet and commits it
//   pkt_discard  abort the packet in progress and free its bytes
//   r_enable     pop the head entry
//   r_data       head entry, first-word-fall-through
//   r_last       head entry is the final byte of its packet
//   empty        no committed entries
//   full         no free entries (committed plus uncommitted)
//   almost_full  free entries <= AF_MARGIN
//   count        committed entries not yet read
//   pkt_count    committed packets not fully read
//   drop         one-cycle pulse when an overflowed packet is thrown away
module nd_pkt_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  int AF_MARGIN  = 2,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  w_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_last,
  input  logic                  pkt_discard,
  input  logic                  r_enable,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_last,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         pkt_count,
  output logic                  drop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Each storage entry holds the data byte plus its last-of-packet flag in the MSB.
  logic [DATA_WIDTH:0] mem [DEPTH];

  // rd_ptr points at the head. cm_ptr points one past the last committed
  // entry. wr_ptr points at the next free entry.
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] cm_ptr;
  logic [PW-1:0] wr_ptr;

  // used counts all occupied entries, committed or not, and drives full.
  // pend counts the bytes of the packet currently being written.
  logic [CW-1:0] used;
  logic [CW-1:0] pend;
  logic          ovf;

  logic [CW-1:0] free_cnt;
  logic          do_read;
  logic          rewind;
  logic          advance;
  logic          commit;
  logic          set_ovf;
  logic          drop_next;
  logic          head_last;

  // Advance a pointer by one, wrapping at DEPTH-1 so DEPTH can be any value.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The read side sees storage directly (first-word-fall-through).
  // Status flags come from the registered occupancy counters.
  assign r_data      = mem[rd_ptr][DATA_WIDTH-1:0];
  assign r_last      = mem[rd_ptr][DATA_WIDTH];
  assign head_last   = mem[rd_ptr][DATA_WIDTH];
  assign empty       = (count == '0);
  assign full        = (used == CW'(DEPTH));
  assign free_cnt    = CW'(DEPTH) - used;
  assign almost_full = (int'(free_cnt) <= AF_MARGIN);

  // Decode what happens at the next edge.
  // A rewind puts wr_ptr back at cm_ptr. A rewind comes from pkt_discard.
  // It also comes from a w_last that finishes a packet which already
  // overflowed, or a w_last that itself arrives while the FIFO is full. A
  // discard beats any write in the same cycle. Only the overflow rewinds
  // pulse drop.
  always_comb begin
    do_read   = 1'b0;
    rewind    = 1'b0;
    advance   = 1'b0;
    commit    = 1'b0;
    set_ovf   = 1'b0;
    drop_next = 1'b0;

    do_read   = r_enable && !empty;
    drop_next = !pkt_discard && w_enable && w_last && (full || ovf);
    rewind    = pkt_discard || drop_next;
    advance   = w_enable && !full && !rewind;
    commit    = advance && w_last;
    set_ovf   = w_enable && full && !w_last && !pkt_discard;
  end

  // Pointer, counter and overflow state.
  // On a commit, count grows by the whole packet (the pending bytes plus
  // this last one). On a rewind, used gives back the pending bytes. A read
  // in the same cycle is always applied on top of either.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr    <= '0;
      cm_ptr    <= '0;
      wr_ptr    <= '0;
      used      <= '0;
      pend      <= '0;
      count     <= '0;
      pkt_count <= '0;
      ovf       <= 1'b0;
      drop      <= 1'b0;
    end else begin
      drop <= drop_next;

      if (do_read) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end

      if (rewind) begin
        wr_ptr <= cm_ptr;
        pend   <= '0;
        ovf    <= 1'b0;
      end else begin
        if (advance) begin
          wr_ptr <= ptr_inc(wr_ptr);
          pend   <= commit ? '0 : pend + CW'(1);
        end
        if (commit) begin
          cm_ptr <= ptr_inc(wr_ptr);
        end
        if (set_ovf) begin
          ovf <= 1'b1;
        end
      end

      used      <= used + CW'(advance) - CW'(do_read) - (rewind ? pend : '0);
      count     <= count - CW'(do_read) + (commit ? pend + CW'(1) : '0);
      pkt_count <= pkt_count + CW'(commit) - CW'(do_read && head_last);
    end
  end

  // Storage array. It is cleared on reset so the outputs read as zero
  // afterwards. A byte is stored only when the write actually claims a free
  // entry. Dropped and rewound writes never touch the array.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (advance) begin
      mem[wr_ptr] <= {w_last, w_data};
    end
  end

endmodule

// File: tb/tb_nd_pkt_fifo.sv
// Self-checking bench for nd_pkt_fifo (DEPTH=8, AF_MARGIN=2).
// A queue-based reference model tracks committed and pending packet bytes.
// After every clock edge the bench compares all DUT outputs with the model.
// The stimulus is a set of directed scenarios followed by a long random run.
module tb_nd_pkt_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          w_enable = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          w_last = 1'b0;
  logic          pkt_discard = 1'b0;
  logic          r_enable = 1'b0;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt_count;
  logic          drop;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. cq holds the committed {last,data} entries in
  // read order. pq holds the bytes of the packet being written.
  logic [DW:0] cq[$];
  logic [DW:0] pq[$];
  bit          m_ovf  = 1'b0;
  bit          m_drop = 1'b0;

  nd_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk(clk), .n_rst(n_rst), .w_enable(w_enable), .w_data(w_data),
    .w_last(w_last), .pkt_discard(pkt_discard), .r_enable(r_enable),
    .r_data(r_data), .r_last(r_last), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .pkt_count(pkt_count),
    .drop(drop)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A committed packet always ends in a last byte, so the number of
  // committed packets equals the number of last flags in cq.
  function automatic int modelPkts();
    int n = 0;
    foreach (cq[i]) if (cq[i][DW]) n++;
    return n;
  endfunction

  // Apply one clock edge's worth of inputs to the model.
  // full is the pre-edge occupancy. A read pops the pre-edge head.
  task automatic modelStep(input bit we, input logic [DW-1:0] wd, input bit wl,
                           input bit disc, input bit re);
    bit fullm;
    fullm  = (cq.size() + pq.size()) == DEPTH;
    m_drop = 1'b0;
    if (re && cq.size() > 0) void'(cq.pop_front());
    if (disc) begin
      pq.delete();
      m_ovf = 1'b0;
    end else if (we) begin
      if (wl && (fullm || m_ovf)) begin
        pq.delete();
        m_ovf  = 1'b0;
        m_drop = 1'b1;
      end else if (fullm) begin
        m_ovf = 1'b1;
      end else begin
        pq.push_back({wl, wd});
        if (wl) begin
          foreach (pq[i]) cq.push_back(pq[i]);
          pq.delete();
        end
      end
    end
  endtask

  // Compare every output with the model. Head data is only defined when
  // something is committed.
  task automatic checkAll();
    int used;
    used = cq.size() + pq.size();
    checkOutput("empty", 32'(empty), 32'(cq.size() == 0));
    checkOutput("full", 32'(full), 32'(used == DEPTH));
    checkOutput("almost_full", 32'(almost_full), 32'((DEPTH - used) <= AFM));
    checkOutput("count", 32'(count), 32'(cq.size()));
    checkOutput("pkt_count", 32'(pkt_count), 32'(modelPkts()));
    checkOutput("drop", 32'(drop), 32'(m_drop));
    if (cq.size() > 0) begin
      checkOutput("r_data", 32'(r_data), 32'(cq[0][DW-1:0]));
      checkOutput("r_last", 32'(r_last), 32'(cq[0][DW]));
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, then
  // sample the DUT 1 ns after the edge.
  task automatic applyStimulus(input bit we, input logic [DW-1:0] wd, input bit wl,
                               input bit disc, input bit re);
    w_enable    = we;
    w_data      = wd;
    w_last      = wl;
    pkt_discard = disc;
    r_enable    = re;
    @(posedge clk);
    modelStep(we, wd, wl, disc, re);
    #1;
    checkAll();
  endtask

  // Assert reset away from a clock edge and check that the outputs clear at
  // once, then release it in step with the clock.
  task automatic doReset();
    w_enable = 0; w_last = 0; pkt_discard = 0; r_enable = 0;
    #2;
    n_rst = 1'b0;
    cq.delete();
    pq.delete();
    m_ovf  = 1'b0;
    m_drop = 1'b0;
    #1;
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_drop", 32'(drop), 32'd0);
    checkOutput("rst_r_data", 32'(r_data), 32'd0);
    checkOutput("rst_r_last", 32'(r_last), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    int rd_pct;
    $display("[TB] nd_pkt_fifo bench start");
    @(posedge clk);
    #1;
    doReset();

    // Basic packet A1,A2,A3, then read it out.
    applyStimulus(1, 8'hA1, 0, 0, 0);
    applyStimulus(1, 8'hA2, 0, 0, 0);
    applyStimulus(1, 8'hA3, 1, 0, 0);
    checkOutput("basic_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Discard a partial packet, then commit {55,66}.
    applyStimulus(1, 8'h11, 0, 0, 0);
    applyStimulus(1, 8'h22, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 8'h55, 0, 0, 0);
    applyStimulus(1, 8'h66, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Overflow: commit 6 bytes, add 3 more of a new packet, then w_last.
    for (int i = 0; i < 6; i++) applyStimulus(1, DW'(8'h30 + i), i == 5, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, DW'(8'h40 + i), 0, 0, 0);
    applyStimulus(1, 8'h4F, 1, 0, 0);
    checkOutput("ovf_drop", 32'(drop), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd6);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1);

    // Wrap-around: 20 three-byte packets, each read back concurrently.
    for (int p = 0; p < 20; p++) begin
      for (int b = 0; b < 3; b++) applyStimulus(1, DW'(p * 3 + b), b == 2, 0, p > 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);

    // A read of packet 1's last byte in the same cycle as the commit of 2-byte packet 2.
    applyStimulus(1, 8'h77, 1, 0, 0);
    applyStimulus(1, 8'h81, 0, 0, 0);
    applyStimulus(1, 8'h82, 1, 0, 1);
    checkOutput("same_cycle_count", 32'(count), 32'd2);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Reset mid-packet with 4 committed bytes.
    for (int i = 0; i < 4; i++) applyStimulus(1, DW'(8'hC0 + i), i == 3, 0, 0);
    applyStimulus(1, 8'hD0, 0, 0, 0);
    doReset();

    // Random run. The read rate changes every 200 cycles so that the FIFO
    // spends time both near full and near empty.
    rd_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rd_pct = $urandom_range(15, 85);
      applyStimulus($urandom_range(0, 99) < 70, DW'($urandom),
                    $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < rd_pct);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nd_pkt_fifo.md
# nd_pkt_fifo

Packet-aware, parametrised FIFO for the USB receiver's non-data path. It replaces the plain byte FIFO used for token and handshake packets. Bytes of a packet become visible to the reader only once the packet is committed. Packets can be aborted mid-stream (PID/CRC error), and overflowing packets are dropped whole rather than truncated. It sits between the receive decoder (write side) and the protocol controller (read side).

## Interface
- DATA_WIDTH, 8: bits per entry.
- DEPTH, 16: number of entries; any value ≥ 2, pointers wrap at DEPTH-1.
- AF_MARGIN, 2: almost_full asserts when free entries ≤ AF_MARGIN.
- CW = $clog2(DEPTH+1): derived width of the count outputs.

- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- w_enable  in  1  write w_data at the write pointer this cycle.
- w_data  in  DATA_WIDTH  write data.
- w_last  in  1  qualifies w_enable; the byte is the packet's final byte, and the packet commits.
- pkt_discard  in  1  abort the packet in progress; uncommitted bytes are freed.
- r_enable  in  1  pop the head entry.
- r_data  out  DATA_WIDTH  head entry, first-word-fall-through.
- r_last  out  1  head entry is the final byte of its packet.
- empty  out  1  no committed entries.
- full  out  1  no free entries; committed and uncommitted entries both count.
- almost_full  out  1  free entries ≤ AF_MARGIN.
- count  out  CW  committed entries not yet read.
- pkt_count  out  CW  committed packets not fully read.
- drop  out  1  one-cycle pulse when a packet is discarded because of overflow.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1) register array; the extra bit is the last flag, written from w_last.
- Pointers:
  - rd_ptr: head.
  - cm_ptr: one past the last committed entry.
  - wr_ptr: next free entry.
  - All pointers advance modulo DEPTH. Occupancy counters are kept separately, so full and empty are never ambiguous.
- Write, when w_enable & !full & !pkt_discard: store {w_last, w_data} at wr_ptr, then wr_ptr++.
  - If w_last is also set and the packet has not overflowed: cm_ptr ← wr_ptr+1, count += bytes in the packet, pkt_count++.
- Overflow: w_enable while full drops the byte and sets the internal ovf flag.
  - The next w_last write, or a w_last arriving while full, or pkt_discard, rewinds wr_ptr ← cm_ptr and clears ovf.
  - The w_last and w_last-while-full cases also pulse drop. pkt_discard does not pulse drop.
  - Overflowed packets never become visible.
- pkt_discard: wr_ptr ← cm_ptr, ovf ← 0. It has priority over a w_enable in the same cycle, and that write is ignored.
- Read, when r_enable & !empty: rd_ptr++, count--. If r_last was 1, pkt_count-- as well.
  - r_enable while empty is ignored, with no state change.
- Simultaneous read and commit in one cycle: count = count − 1 + committed bytes; pkt_count is adjusted by both terms.
- Simultaneous read and write when full: the read is honoured, the write is dropped and counts as overflow. full is evaluated on registered state.
- count never exceeds DEPTH; pkt_count ≤ count.

## Timing
- Reset (async assert, sync release):
  - All pointers, counters and ovf are 0.
  - empty=1, full=0, almost_full=0 (assuming AF_MARGIN < DEPTH), count=0, pkt_count=0, drop=0.
  - r_data and r_last read as 0, because storage is cleared on reset.
- Reset mid-packet loses all data, committed and uncommitted, with no drop pulse.
- Commit latency: on a w_last write at edge N, empty deasserts and count/pkt_count update after edge N, so they are visible in cycle N+1.
- r_data and r_last are combinational from storage[rd_ptr]. They are valid whenever empty=0, and the next entry appears in the cycle after the r_enable edge.
- full and almost_full reflect wr_ptr occupancy and update on the edge after the write, discard or read that changes them.
- drop is registered: high for exactly one cycle, following the edge that performed the rewind.

## Test plan
- DEPTH=8. Write 3 bytes A1,A2,A3 with w_last on A3, with empty=1 during the writes. Expect empty=0, count=3, pkt_count=1 the cycle after A3. Read 3 times: r_data A1,A2,A3; r_last=1 only on A3; then empty=1, pkt_count=0.
- Write 2 bytes, then pkt_discard, then write packet {55,66 last}. Expect only 55,66 readable, count=2, and no drop pulse.
- DEPTH=8 with 6 bytes committed: write 3 more bytes of a new packet. full=1 after the 2nd byte, and the 3rd byte sets ovf. Then w_last. Expect drop pulse, wr_ptr rewound, count=6, full=0.
- Wrap-around: 20 sequential packets of 3 bytes, each read out concurrently. Expect data order preserved, no spurious full/empty, and pointers wrap cleanly.
- Same cycle: read of the last byte of packet 1 and a w_last commit of 2-byte packet 2. Expect count 1→2, pkt_count 1→1, empty stays 0.
- Assert n_rst mid-packet with 4 committed bytes. Expect immediately empty=1, count=0, full=0, drop=0.
